// File: rtl/bht_port_sched.sv
// -----------------------------------------------------------------------------
// bht_port_sched
//   Owns the single read/write port of a bimodal branch history table of 2-bit
//   saturating counters. After reset it writes weakly-taken (2'b10) into every
//   entry, one entry per cycle. It then grants the port each cycle to exactly
//   one of:
//     - a queued counter update (always chosen when the queue is full),
//     - a lane-0 lookup,
//     - a lane-1 lookup,
//     - a queued counter update (when nothing else is pending).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   lk0_valid/pc/ready        lane-0 prediction lookup (ready = granted now)
//   lk1_valid/pc/ready        lane-1 prediction lookup
//   rsp_valid/lane/taken/ctr  lookup response, one cycle after the grant
//   upd_valid/pc/ctr/taken    resolved-branch update offered by execute
//   upd_ready                 update queue can accept this cycle
//   bht_req/we/idx/wdata      table port; bht_rdata returns one cycle after a read
//   init_done                 table initialised, lookups/updates being served
// -----------------------------------------------------------------------------
module bht_port_sched #(
    parameter int IDX_W  = 12,
    parameter int PC_W   = 14,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk0_valid,
    input  logic [PC_W-1:0]  lk0_pc,
    output logic             lk0_ready,
    input  logic             lk1_valid,
    input  logic [PC_W-1:0]  lk1_pc,
    output logic             lk1_ready,
    output logic             rsp_valid,
    output logic             rsp_lane,
    output logic             rsp_taken,
    output logic [1:0]       rsp_ctr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [1:0]       upd_ctr,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             bht_req,
    output logic             bht_we,
    output logic [IDX_W-1:0] bht_idx,
    output logic [1:0]       bht_wdata,
    input  logic [1:0]       bht_rdata,
    output logic             init_done
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   init_ptr_r;
    logic [IDX_W-1:0]   fifo_idx_r [QDEPTH];
    logic [1:0]         fifo_ctr_r [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               rsp_valid_r;
    logic               rsp_lane_r;
    logic               init_done_r;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               grant0_s;
    logic               grant1_s;
    logic               unused_pc_bits_s;

    // Table index taken from the word-aligned part of a PC.
    function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_W-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    // Two-bit saturating counter step.
    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        case ({taken, ctr})
            3'b1_00:         res = 2'b01;
            3'b1_01:         res = 2'b10;
            3'b1_10, 3'b1_11: res = 2'b11;
            3'b0_11:         res = 2'b10;
            3'b0_10:         res = 2'b01;
            3'b0_01, 3'b0_00: res = 2'b00;
            default:         res = 2'b10;
        endcase
        return res;
    endfunction

    // Only the index bits of the PCs matter; fold the rest away explicitly.
    assign unused_pc_bits_s = ^{lk0_pc, lk1_pc, upd_pc};

    assign full_s  = (count_r == CNT_W'(QDEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Queue acceptance only looks at registered occupancy, so a same-cycle pop
    // of a full queue does not open a slot.
    assign upd_ready = !rst && (state_r == ST_RUN) && !full_s;
    assign push_s    = upd_valid && upd_ready;

    assign lk0_ready = grant0_s;
    assign lk1_ready = grant1_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_lane  = rsp_lane_r;
    assign rsp_ctr   = rsp_valid_r ? bht_rdata : 2'b00;
    assign rsp_taken = rsp_ctr[1];
    assign init_done = init_done_r;

    // Next state, port arbitration and table port drive; port stays quiet in reset.
    always_comb begin
        state_s   = state_r;
        grant0_s  = 1'b0;
        grant1_s  = 1'b0;
        pop_s     = 1'b0;
        bht_req   = 1'b0;
        bht_we    = 1'b0;
        bht_idx   = {IDX_W{1'b0}};
        bht_wdata = 2'b00;
        if (rst) begin
            state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    bht_req   = 1'b1;
                    bht_we    = 1'b1;
                    bht_idx   = init_ptr_r;
                    bht_wdata = 2'b10;
                    if (init_ptr_r == {IDX_W{1'b1}}) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_INIT;
                    end
                end
                ST_RUN: begin
                    // A full queue overrides lookups so updates always drain.
                    if (full_s) begin
                        pop_s = 1'b1;
                    end else if (lk0_valid) begin
                        grant0_s = 1'b1;
                    end else if (lk1_valid) begin
                        grant1_s = 1'b1;
                    end else if (!empty_s) begin
                        pop_s = 1'b1;
                    end else begin
                        pop_s = 1'b0;
                    end

                    if (pop_s) begin
                        bht_req   = 1'b1;
                        bht_we    = 1'b1;
                        bht_idx   = fifo_idx_r[rd_ptr_r];
                        bht_wdata = fifo_ctr_r[rd_ptr_r];
                    end else if (grant0_s) begin
                        bht_req = 1'b1;
                        bht_idx = pc_idx(lk0_pc);
                    end else if (grant1_s) begin
                        bht_req = 1'b1;
                        bht_idx = pc_idx(lk1_pc);
                    end else begin
                        bht_req = 1'b0;
                    end
                end
                default: begin
                    state_s = ST_INIT;
                end
            endcase
        end
    end

    // State, init walk, queue pointers/occupancy and response tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            init_ptr_r  <= {IDX_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_lane_r  <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_done_r <= (state_s == ST_RUN);
            rsp_valid_r <= grant0_s || grant1_s;
            rsp_lane_r  <= grant1_s;
            if (state_r == ST_INIT) begin
                init_ptr_r <= init_ptr_r + IDX_W'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage: target index and the already-saturated counter value.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_idx_r[wr_ptr_r] <= pc_idx(upd_pc);
            fifo_ctr_r[wr_ptr_r] <= sat_next(upd_ctr, upd_taken);
        end
    end

endmodule

// File: tb/tb_bht_port_sched.sv
module tb_bht_port_sched;

    localparam int IDX_W  = 4;
    localparam int PC_W   = 8;
    localparam int QDEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             lk0_valid, lk1_valid, upd_valid, upd_taken;
    logic [PC_W-1:0]  lk0_pc, lk1_pc, upd_pc;
    logic [1:0]       upd_ctr;
    logic             lk0_ready, lk1_ready, rsp_valid, rsp_lane, rsp_taken, upd_ready;
    logic [1:0]       rsp_ctr;
    logic             bht_req, bht_we, init_done;
    logic [IDX_W-1:0] bht_idx;
    logic [1:0]       bht_wdata;
    logic [1:0]       bht_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic [1:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] due;
        logic        lane;
        logic [1:0]  ctr;
    } rsp_t;

    wr_t        exp_wr[$];
    rsp_t       exp_rsp[$];
    logic [1:0] exp_tbl [16];
    logic [1:0] mem [16];

    bht_port_sched #(.IDX_W(IDX_W), .PC_W(PC_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .lk0_valid(lk0_valid), .lk0_pc(lk0_pc), .lk0_ready(lk0_ready),
        .lk1_valid(lk1_valid), .lk1_pc(lk1_pc), .lk1_ready(lk1_ready),
        .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_taken(rsp_taken), .rsp_ctr(rsp_ctr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ctr(upd_ctr), .upd_taken(upd_taken),
        .upd_ready(upd_ready),
        .bht_req(bht_req), .bht_we(bht_we), .bht_idx(bht_idx), .bht_wdata(bht_wdata),
        .bht_rdata(bht_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Table storage model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (bht_req === 1'b1 && bht_we === 1'b1) mem[bht_idx] <= bht_wdata;
        if (bht_req === 1'b1 && bht_we === 1'b0) bht_rdata <= mem[bht_idx];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else   return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Scoreboard: every table write and every response is matched in order.
    always @(negedge clk) begin : monitor
        wr_t  w;
        rsp_t r;
        if (bht_req === 1'b1 && bht_we === 1'b1) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("wr_idx", 32'(bht_idx), 32'(w.idx));
                check("wr_data", 32'(bht_wdata), 32'(w.data));
                exp_tbl[w.idx] = w.data;
            end
        end
        if (rsp_valid === 1'b1) begin
            check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
            if (exp_rsp.size() != 0) begin
                r = exp_rsp.pop_front();
                check("rsp_cycle", 32'(cyc), r.due);
                check("rsp_lane", 32'(rsp_lane), 32'(r.lane));
                check("rsp_ctr", 32'(rsp_ctr), 32'(r.ctr));
                check("rsp_taken", 32'(rsp_taken), 32'(r.ctr[1]));
            end
        end else if (exp_rsp.size() != 0 && exp_rsp[0].due <= 32'(cyc)) begin
            r = exp_rsp.pop_front();
            check("rsp_missing", 32'(rsp_valid), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_rsp(input logic lane, input logic [PC_W-1:0] pc);
        exp_rsp.push_back({32'(cyc + 1), lane, exp_tbl[pc[5:2]]});
    endtask

    // Starts at a drive point with rst high; ends at a drive point in RUN.
    task automatic run_init();
        exp_wr.delete();
        exp_rsp.delete();
        for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 2'b10});
        rst = 1'b0;
        lk0_valid = 1'b1; lk0_pc = 8'h08;
        lk1_valid = 1'b1; lk1_pc = 8'h0C;
        upd_valid = 1'b1; upd_pc = 8'h08; upd_ctr = 2'b00; upd_taken = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sample();
            check("init_readies", 32'({lk0_ready, lk1_ready, upd_ready, init_done}), 32'd0);
            check("init_write", 32'({bht_req, bht_we}), 32'b11);
            if (i < 15) step();
        end
        step();
        lk0_valid = 1'b0; lk1_valid = 1'b0; upd_valid = 1'b0;
        sample();
        check("init_done", 32'(init_done), 32'd1);
        check("init_writes_left", 32'(exp_wr.size()), 32'd0);
        check("run_idle", 32'(bht_req), 32'd0);
        step();
    endtask

    task automatic push_upd(input logic [PC_W-1:0] pc, input logic [1:0] c, input logic t);
        bit done = 1'b0;
        upd_valid = 1'b1; upd_pc = pc; upd_ctr = c; upd_taken = t;
        for (int k = 0; k < 20 && !done; k++) begin
            sample();
            if (upd_ready === 1'b1) begin
                exp_wr.push_back({pc[5:2], model_sat(c, t)});
                done = 1'b1;
            end
            step();
        end
        upd_valid = 1'b0;
        check("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic lookup(input logic lane, input logic [PC_W-1:0] pc);
        bit done = 1'b0;
        if (lane) begin lk1_valid = 1'b1; lk1_pc = pc; end
        else      begin lk0_valid = 1'b1; lk0_pc = pc; end
        for (int k = 0; k < 20 && !done; k++) begin
            sample();
            if ((lane ? lk1_ready : lk0_ready) === 1'b1) begin
                check("lk_read", 32'({bht_req, bht_we, bht_idx}), 32'({2'b10, pc[5:2]}));
                expect_rsp(lane, pc);
                done = 1'b1;
            end
            step();
        end
        lk0_valid = 1'b0; lk1_valid = 1'b0;
        check("lk_granted", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && exp_wr.size() != 0; k++) begin
            sample();
            step();
        end
        check("drain_empty", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lk0_valid = 1'b1; lk0_pc = 8'h08;
        lk1_valid = 1'b1; lk1_pc = 8'h0C;
        upd_valid = 1'b1; upd_pc = 8'h08; upd_ctr = 2'b00; upd_taken = 1'b0;

        // Reset with every request raised: outputs must stay at zero.
        repeat (3) step();
        sample();
        check("rst_outputs", 32'({bht_req, bht_we, lk0_ready, lk1_ready, upd_ready, rsp_valid, init_done}), 32'd0);
        check("rst_port", 32'({bht_idx, bht_wdata}), 32'd0);
        step();
        run_init();

        // Both lanes together: lane 0 first, lane 1 the next cycle.
        lk0_valid = 1'b1; lk0_pc = 8'h08;
        lk1_valid = 1'b1; lk1_pc = 8'h0C;
        sample();
        check("arb_lk0", 32'({lk0_ready, lk1_ready}), 32'b10);
        check("arb_rd0", 32'({bht_req, bht_we, bht_idx}), 32'({2'b10, 4'd2}));
        expect_rsp(1'b0, 8'h08);
        step();
        lk0_valid = 1'b0;
        sample();
        check("arb_lk1", 32'({lk0_ready, lk1_ready}), 32'b01);
        check("arb_rd1", 32'({bht_req, bht_we, bht_idx}), 32'({2'b10, 4'd3}));
        expect_rsp(1'b1, 8'h0C);
        step();
        lk1_valid = 1'b0;
        sample();
        check("arb_idle", 32'(bht_req), 32'd0);
        step();

        // Single updates written the cycle after acceptance, both saturation ends.
        push_upd(8'h08, 2'b10, 1'b1);
        sample();
        check("upd_wr_next", 32'({bht_req, bht_we, bht_idx}), 32'({2'b11, 4'd2}));
        step();
        push_upd(8'h08, 2'b00, 1'b0);
        sample();
        check("upd_wr_next", 32'({bht_req, bht_we, bht_idx}), 32'({2'b11, 4'd2}));
        step();
        lookup(1'b0, 8'h08);
        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 2; t++) begin
                push_upd(8'h24, 2'(c), 1'(t));
                sample();
                check("sat_wr", 32'({bht_req, bht_we, bht_idx}), 32'({2'b11, 4'd9}));
                step();
            end
        end

        // Lane 0 held: queue fills, then the full queue wins the port.
        lk0_valid = 1'b1; lk0_pc = 8'h10;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1; upd_pc = 8'(8'h14 + 4 * i); upd_ctr = 2'(i); upd_taken = 1'(i % 2);
            sample();
            check("fill", 32'({lk0_ready, upd_ready, bht_we}), 32'b110);
            expect_rsp(1'b0, 8'h10);
            exp_wr.push_back({upd_pc[5:2], model_sat(upd_ctr, upd_taken)});
            step();
        end
        upd_valid = 1'b0;
        sample();
        check("full_override", 32'({upd_ready, lk0_ready, bht_req, bht_we, bht_idx}), 32'({4'b0011, 4'd5}));
        step();
        sample();
        check("after_full", 32'({lk0_ready, upd_ready, bht_we}), 32'b110);
        expect_rsp(1'b0, 8'h10);
        step();
        lk0_valid = 1'b0;
        drain();

        // Occupancy 2 with simultaneous push and pop; pointers wrap.
        lk0_valid = 1'b1; lk0_pc = 8'h10;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) lk0_valid = 1'b0;
            upd_valid = 1'b1; upd_pc = 8'(8'h28 + 4 * i); upd_ctr = 2'(3 - (i % 4)); upd_taken = 1'(i > 2);
            sample();
            if (i < 2) begin
                check("occ_fill", 32'({lk0_ready, upd_ready, bht_we}), 32'b110);
                expect_rsp(1'b0, 8'h10);
            end else begin
                check("occ_steady", 32'({lk0_ready, upd_ready, bht_req, bht_we}), 32'b0111);
            end
            exp_wr.push_back({upd_pc[5:2], model_sat(upd_ctr, upd_taken)});
            step();
        end
        upd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            check("occ_tail", 32'({bht_req, bht_we}), 32'b11);
            step();
        end
        sample();
        check("occ_empty", 32'(bht_req), 32'd0);
        check("occ_drained", 32'(exp_wr.size()), 32'd0);
        step();

        // Reset in RUN with three queued updates and a read just granted.
        lk0_valid = 1'b1; lk0_pc = 8'h10;
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1; upd_pc = 8'(8'h04 + 4 * i); upd_ctr = 2'b01; upd_taken = 1'b1;
            sample();
            check("q3_fill", 32'({lk0_ready, upd_ready}), 32'b11);
            expect_rsp(1'b0, 8'h10);
            exp_wr.push_back({upd_pc[5:2], model_sat(upd_ctr, upd_taken)});
            step();
        end
        upd_valid = 1'b0;
        sample();
        check("pending_rd", 32'({lk0_ready, bht_we}), 32'b10);
        #1;
        rst = 1'b1; lk0_valid = 1'b0;
        exp_wr.delete();
        exp_rsp.delete();
        step();
        sample();
        check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_quiet", 32'({bht_req, upd_ready, init_done}), 32'd0);
        step();
        run_init();
        for (int k = 0; k < 3; k++) begin
            sample();
            check("no_stale_wr", 32'(bht_req), 32'd0);
            step();
        end

        // Reset in the middle of initialisation at index 7.
        rst = 1'b1;
        step();
        exp_wr.delete();
        for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 2'b10});
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (i < 7) step();
        end
        check("mid_init_ptr", 32'({bht_req, bht_we, bht_idx}), 32'({2'b11, 4'd7}));
        #1;
        rst = 1'b1;
        exp_wr.delete();
        step();
        sample();
        check("mid_rst_quiet", 32'({bht_req, init_done}), 32'd0);
        step();
        run_init();
        lookup(1'b1, 8'h1C);
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
